// File: rtl/addsub_pkg.sv
// Shared constants and types for the shared add/sub arbiter slice.
package addsub_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic REQ0   = 1'b0;
  localparam logic REQ1   = 1'b1;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostage_e;

endpackage

// File: rtl/four_bit_adder_subtractor.sv
// 4-bit add/subtract datapath; subtraction adds the two's complement of b, carry-in fixed at 0.
module four_bit_adder_subtractor
  import addsub_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] b_eff;
  logic       cin;

  assign cin   = 1'b0;
  // ~b + 1 wraps to 0 for b == 0, so a - 0 reports no carry.
  assign b_eff = (sub == OP_SUB) ? (~b + 4'd1) : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {4'd0, cin};

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arb2
  import addsub_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (ptr_q == REQ1) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[REQ0])      ptr_d = REQ1;
    else if (gnt[REQ1]) ptr_d = REQ0;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= REQ0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/addsub_share_arbiter.sv
// Shares one four_bit_adder_subtractor between two valid/ready requesters with a
// single-entry registered result stage and a consumed-result counter.
//
//   state    | meaning
//   ST_EMPTY | no result held, res_valid=0
//   ST_FULL  | result held, res_valid=1, waiting for res_ready
module addsub_share_arbiter
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_cout,
  output logic             res_id,
  output logic [CNT_W-1:0] op_count
);

  ostage_e          state_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic             cout_q, cout_d;
  logic             id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             can_accept;
  logic [1:0]       gnt;
  logic             any_gnt;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_sub;
  logic [WIDTH-1:0] dp_sum;
  logic             dp_cout;

  assign can_accept = (state_q == ST_EMPTY) | res_ready;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({req1_valid, req0_valid}),
    .en  (can_accept & ~rst),
    .gnt (gnt)
  );

  assign any_gnt    = |gnt;
  assign req0_ready = gnt[REQ0];
  assign req1_ready = gnt[REQ1];

  assign op_a   = gnt[REQ1] ? req1_a   : req0_a;
  assign op_b   = gnt[REQ1] ? req1_b   : req0_b;
  assign op_sub = gnt[REQ1] ? req1_sub : req0_sub;

  four_bit_adder_subtractor u_dp (
    .a    (op_a),
    .b    (op_b),
    .sub  (op_sub),
    .sum  (dp_sum),
    .cout (dp_cout)
  );

  always_comb begin
    data_d = data_q;
    cout_d = cout_q;
    id_d   = id_q;
    cnt_d  = cnt_q;
    if (any_gnt) begin
      data_d = dp_sum;
      cout_d = dp_cout;
      id_d   = gnt[REQ1] ? REQ1 : REQ0;
    end
    if ((state_q == ST_FULL) && res_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      cout_q  <= 1'b0;
      id_q    <= REQ0;
      cnt_q   <= '0;
    end else begin
      data_q <= data_d;
      cout_q <= cout_d;
      id_q   <= id_d;
      cnt_q  <= cnt_d;
      // a grant always refills the stage, even while the old result drains
      if (any_gnt)        state_q <= ST_FULL;
      else if (res_ready) state_q <= ST_EMPTY;
    end
  end

  assign res_valid = (state_q == ST_FULL);
  assign res_data  = data_q;
  assign res_cout  = cout_q;
  assign res_id    = id_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Self-checking bench for addsub_share_arbiter: directed table, corner sequences, random traffic vs reference model.
module tb_addsub_share_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_sub;
  logic [3:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_sub;
  logic [3:0] req1_a, req1_b;
  logic       res_valid, res_ready, res_cout, res_id;
  logic [3:0] res_data;
  logic [7:0] op_count;

  always #5 clk = ~clk;

  addsub_share_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_cout(res_cout), .res_id(res_id),
    .op_count(op_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic       m_valid;
  logic [3:0] m_data;
  logic       m_cout;
  logic       m_id;
  logic [7:0] m_cnt;
  int         m_prio;
  int         last_g;

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic       sub;
    logic [3:0] d;
    logic       c;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void calc(input logic [3:0] a, input logic [3:0] b, input logic s,
                               output logic [3:0] d, output logic c);
    int r;
    if (!s)          r = int'(a) + int'(b);
    else if (b == 0) r = int'(a);
    else             r = int'(a) + 16 - int'(b);
    d = 4'(r % 16);
    c = (r >= 16);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = 4'd0; m_cout = 1'b0; m_id = 1'b0; m_cnt = 8'd0; m_prio = 0;
  endtask

  // Called at a negedge with inputs already driven; advances one clock.
  task automatic cycle();
    int g;
    logic [3:0] d;
    logic c;
    #1;
    g = -1;
    if (!rst && (!m_valid || res_ready)) begin
      if (req0_valid && req1_valid) g = m_prio;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
    end
    last_g = g;
    chk("req0_ready", int'(req0_ready), int'(g == 0));
    chk("req1_ready", int'(req1_ready), int'(g == 1));
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (m_valid && res_ready) m_cnt = m_cnt + 8'd1;
      if (g >= 0) begin
        if (g == 0) calc(req0_a, req0_b, req0_sub, d, c);
        else        calc(req1_a, req1_b, req1_sub, d, c);
        m_data = d; m_cout = c; m_id = (g == 1); m_valid = 1'b1; m_prio = 1 - g;
      end else if (res_ready) m_valid = 1'b0;
    end
    @(negedge clk);
    chk("res_valid", int'(res_valid), int'(m_valid));
    chk("op_count", int'(op_count), int'(m_cnt));
    if (m_valid) begin
      chk("res_data", int'(res_data), int'(m_data));
      chk("res_cout", int'(res_cout), int'(m_cout));
      chk("res_id", int'(res_id), int'(m_id));
    end
  endtask

  task automatic drive(input logic v0, input logic [3:0] a0, input logic [3:0] b0, input logic s0,
                       input logic v1, input logic [3:0] a1, input logic [3:0] b1, input logic s1);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{id:1'b0, a:4'd5,  b:4'd3,  sub:1'b0, d:4'd8,  c:1'b0};
    vt[1] = '{id:1'b1, a:4'd5,  b:4'd3,  sub:1'b1, d:4'd2,  c:1'b1};
    vt[2] = '{id:1'b1, a:4'd3,  b:4'd5,  sub:1'b1, d:4'd14, c:1'b0};
    vt[3] = '{id:1'b0, a:4'd9,  b:4'd9,  sub:1'b0, d:4'd2,  c:1'b1};
    vt[4] = '{id:1'b0, a:4'd0,  b:4'd0,  sub:1'b1, d:4'd0,  c:1'b0};
    vt[5] = '{id:1'b1, a:4'd15, b:4'd1,  sub:1'b0, d:4'd0,  c:1'b1};
    vt[6] = '{id:1'b0, a:4'd7,  b:4'd15, sub:1'b1, d:4'd8,  c:1'b0};
    vt[7] = '{id:1'b1, a:4'd15, b:4'd15, sub:1'b1, d:4'd0,  c:1'b1};

    rst = 1'b1; res_ready = 1'b1;
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    do_reset();
    chk("reset_res_data", int'(res_data), 0);
    chk("reset_res_id", int'(res_id), 0);

    // directed single operations from the table
    for (int i = 0; i < 8; i++) begin
      if (vt[i].id) drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, vt[i].a, vt[i].b, vt[i].sub);
      else          drive(1'b1, vt[i].a, vt[i].b, vt[i].sub, 1'b0, 4'd0, 4'd0, 1'b0);
      cycle();
      chk($sformatf("vec%0d_data", i), int'(res_data), int'(vt[i].d));
      chk($sformatf("vec%0d_cout", i), int'(res_cout), int'(vt[i].c));
      chk($sformatf("vec%0d_id", i), int'(res_id), int'(vt[i].id));
    end

    // contention after reset: grants alternate starting at requester 0
    do_reset();
    drive(1'b1, 4'd1, 4'd2, 1'b0, 1'b1, 4'd9, 4'd4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("rr_grant_seq", last_g, k % 2);
    end

    // backpressure: stage full, no grants while res_ready=0
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_no_grant", last_g, -1);
    end
    res_ready = 1'b1;
    cycle();
    chk("bp_resume_grant", last_g, 0);

    // reset with a held result, then requester 0 wins first
    res_ready = 1'b0;
    cycle();
    do_reset();
    chk("midrst_valid", int'(res_valid), 0);
    chk("midrst_count", int'(op_count), 0);
    res_ready = 1'b1;
    cycle();
    chk("post_rst_grant", last_g, 0);

    // op_count wrap: 256 consumed results
    do_reset();
    drive(1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    for (int i = 1; i <= 257; i++) begin
      cycle();
      if (i == 256) chk("wrap_255", int'(op_count), 255);
    end
    chk("wrap_0", int'(op_count), 0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(63) == 0);
      res_ready = ($urandom_range(3) != 0);
      drive(1'($urandom_range(1)), 4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)),
            1'($urandom_range(1)), 4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
      cycle();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
